ram_arbiter: RTL
================

# ram_arbiter

Shares the single main-memory port between the instruction cache and the data cache. Each cache raises a level request on a miss and holds it until it sees its one-cycle ready pulse. The arbiter grants one requester at a time, alternating on conflicts so neither side starves. It drives the RAM read/write handshake and returns the fetched word to the granted cache. It sits between the two cache controllers and the RAM model, and exports a contention counter for cache analysis.

## Interface
- ADDR_W, 32, address width of every address port
- DATA_W, 32, word width of every data port
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- instRead  in  1  instruction-cache read request; held until instReady
- instAddress  in  ADDR_W  instruction fetch address
- instData  out  DATA_W  word returned to the instruction cache
- instReady  out  1  one-cycle completion pulse for the instruction cache
- dataRead  in  1  data-cache read request; held until dataReady
- dataWrite  in  1  data-cache write request; held until dataReady
- dataAddress  in  ADDR_W  data-side address
- dataWriteData  in  DATA_W  data-side store word
- dataData  out  DATA_W  word returned to the data cache
- dataReady  out  1  one-cycle completion pulse for the data cache
- ramRead  out  1  RAM read strobe; held until ramReady
- ramWrite  out  1  RAM write strobe; held until ramReady
- ramAddress  out  ADDR_W  latched address of the current transaction
- ramWriteData  out  DATA_W  latched store word
- ramReadData  in  DATA_W  RAM read data; valid while ramReady=1
- ramReady  in  1  RAM completion, sampled on clock edge
- busy  out  1  high in BUSY_I, BUSY_D and RELEASE
- conflictCount  out  32  count of IDLE cycles in which both sides requested

## Operation
- States:
  - IDLE: no transaction.
  - BUSY_I: instruction-cache transaction in flight.
  - BUSY_D: data-cache transaction in flight.
  - RELEASE: fixed one-cycle gap between transactions.
- Reset (reset=0, asynchronous), every register goes to its reset value:
  - state IDLE, lastGrant=DATA.
  - All outputs 0: instData, dataData, instReady, dataReady, ramRead, ramWrite, ramAddress, ramWriteData, conflictCount.
- Request definitions:
  - instReq = instRead.
  - dataReq = dataRead | dataWrite.
  - If dataRead and dataWrite are both high, the operation is a write.
- IDLE behaviour:
  - Only one side requesting: that side is granted.
  - Both sides requesting: the side that is NOT lastGrant wins, and conflictCount increments (saturates at 0xFFFFFFFF).
  - On grant:
    - Latch address and, for data writes, the store word into ramAddress/ramWriteData.
    - Set ramRead or ramWrite.
    - Set lastGrant to the granted side.
    - Go to BUSY_I or BUSY_D.
- BUSY_x behaviour:
  - ramReady=0: hold all RAM outputs stable.
  - ramReady=1:
    - Clear ramRead and ramWrite.
    - Pulse xReady for one cycle.
    - On reads, load ramReadData into xData.
    - Go to RELEASE.
  - On writes, xData keeps its previous value.
- RELEASE: clear the ready pulse, then go to IDLE. No grant is issued in RELEASE.
- Requests dropped mid-transaction are ignored. The transaction still completes and xReady still pulses.
- ramReady arriving in IDLE or RELEASE is ignored.
- instData and dataData hold their last value until that port's next read completion.
- Request inputs are sampled only in IDLE.

## Timing
- Edge E0: IDLE sees a request. From E0 on, ramRead/ramWrite=1 and ramAddress is valid.
- Edge En: first edge with ramReady=1 (n≥1). From En on:
  - ramRead/ramWrite=0.
  - xReady=1.
  - xData is valid.
- Edge En+1: xReady=0 and state is IDLE.
- Earliest next grant is edge En+2.
- Minimum request-to-ready latency is 2 cycles: request before E0, ramReady before E1.
- xReady is never high for more than one cycle.
- instReady and dataReady are never high together.
- ramRead and ramWrite are never high together.
- Back-to-back conflicts strictly alternate I, D, I, D.
- Asserting reset in BUSY_x aborts the transaction: no ready pulse is issued and all outputs clear immediately.

## Test plan
- Single fetch:
  - Stimulus: instRead=1, instAddress=0x40; RAM answers 0xDEADBEEF with ramReady 3 cycles after ramRead rises.
  - Required: ramAddress=0x40; instData=0xDEADBEEF with one instReady pulse; busy drops 1 cycle after instReady.
- Data write:
  - Stimulus: dataWrite=1 and dataRead=1, dataAddress=0x100, dataWriteData=0x12345678.
  - Required: ramWrite=1, ramRead=0, ramWriteData=0x12345678; dataReady pulses once; dataData unchanged.
- First conflict after reset:
  - Stimulus: both sides request in the same cycle.
  - Required: instruction side served first, then data side; conflictCount=1; one idle RELEASE cycle between the two ramRead assertions.
- Starvation check:
  - Stimulus: both sides hold requests continuously, re-raising immediately after each ready, for 6 transactions.
  - Required: grant order I,D,I,D,I,D; conflictCount=6.
- Reset mid-transaction:
  - Stimulus: reset=0 while in BUSY_D, before ramReady arrives.
  - Required: immediate ramRead=0, dataReady=0, busy=0, conflictCount=0; after release, a new instRead is granted first.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - cache/RAM handshake bundle for the ram arbiter
interface ram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              instRead;
  logic [ADDR_W-1:0] instAddress;
  logic [DATA_W-1:0] instData;
  logic              instReady;
  logic              dataRead;
  logic              dataWrite;
  logic [ADDR_W-1:0] dataAddress;
  logic [DATA_W-1:0] dataWriteData;
  logic [DATA_W-1:0] dataData;
  logic              dataReady;
  logic              ramRead;
  logic              ramWrite;
  logic [ADDR_W-1:0] ramAddress;
  logic [DATA_W-1:0] ramWriteData;
  logic [DATA_W-1:0] ramReadData;
  logic              ramReady;
  logic              busy;
  logic [31:0]       conflictCount;

  modport slave (
    input  instRead, instAddress, dataRead, dataWrite, dataAddress, dataWriteData,
           ramReadData, ramReady,
    output instData, instReady, dataData, dataReady, ramRead, ramWrite,
           ramAddress, ramWriteData, busy, conflictCount
  );

  modport master (
    output instRead, instAddress, dataRead, dataWrite, dataAddress, dataWriteData,
           ramReadData, ramReady,
    input  instData, instReady, dataData, dataReady, ramRead, ramWrite,
           ramAddress, ramWriteData, busy, conflictCount
  );
endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - shares one RAM port between instruction and data caches
module ram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          clock,
  input  logic          reset,
  ram_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RELEASE} state_t;
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] inst_data_q, inst_data_d;
  logic [DATA_W-1:0] data_data_q, data_data_d;
  logic              inst_ready_q, inst_ready_d;
  logic              data_ready_q, data_ready_d;
  logic              ram_read_q, ram_read_d;
  logic              ram_write_q, ram_write_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [31:0]       conflict_q, conflict_d;
  logic              inst_req, data_req;

  assign inst_req = bus.instRead;
  assign data_req = bus.dataRead | bus.dataWrite;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    inst_data_d  = inst_data_q;
    data_data_d  = data_data_q;
    inst_ready_d = 1'b0;
    data_ready_d = 1'b0;
    ram_read_d   = ram_read_q;
    ram_write_d  = ram_write_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    conflict_d   = conflict_q;
    case (state_q)
      IDLE: begin
        if (inst_req && data_req && conflict_q != 32'hFFFF_FFFF)
          conflict_d = conflict_q + 32'd1;
        // On a conflict the side that did not win last time goes first
        if (inst_req && (!data_req || last_grant_q == GRANT_D)) begin
          ram_addr_d   = bus.instAddress;
          ram_read_d   = 1'b1;
          last_grant_d = GRANT_I;
          state_d      = BUSY_I;
        end else if (data_req) begin
          ram_addr_d = bus.dataAddress;
          if (bus.dataWrite) begin
            ram_write_d = 1'b1;
            ram_wdata_d = bus.dataWriteData;
          end else begin
            ram_read_d = 1'b1;
          end
          last_grant_d = GRANT_D;
          state_d      = BUSY_D;
        end
      end
      BUSY_I: begin
        if (bus.ramReady) begin
          ram_read_d   = 1'b0;
          inst_ready_d = 1'b1;
          inst_data_d  = bus.ramReadData;
          state_d      = RELEASE;
        end
      end
      BUSY_D: begin
        if (bus.ramReady) begin
          if (ram_read_q) data_data_d = bus.ramReadData;
          ram_read_d   = 1'b0;
          ram_write_d  = 1'b0;
          data_ready_d = 1'b1;
          state_d      = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_D;
      inst_data_q  <= '0;
      data_data_q  <= '0;
      inst_ready_q <= 1'b0;
      data_ready_q <= 1'b0;
      ram_read_q   <= 1'b0;
      ram_write_q  <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      conflict_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      inst_data_q  <= inst_data_d;
      data_data_q  <= data_data_d;
      inst_ready_q <= inst_ready_d;
      data_ready_q <= data_ready_d;
      ram_read_q   <= ram_read_d;
      ram_write_q  <= ram_write_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      conflict_q   <= conflict_d;
    end
  end

  assign bus.instData      = inst_data_q;
  assign bus.dataData      = data_data_q;
  assign bus.instReady     = inst_ready_q;
  assign bus.dataReady     = data_ready_q;
  assign bus.ramRead       = ram_read_q;
  assign bus.ramWrite      = ram_write_q;
  assign bus.ramAddress    = ram_addr_q;
  assign bus.ramWriteData  = ram_wdata_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.conflictCount = conflict_q;
endmodule
